// File: rtl/uart_rx.sv
// uart_rx: receives 8N1-style frames by sampling the synchronized line mid-bit, and pulses rx_valid once per good byte.
// Defining UART_RX_PARITY_EN adds an even-parity bit after the data bits and a parity_err output.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS = 8,
    parameter int CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    logic sync1, rxs;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n, perr_n;
`endif

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1     <= rx;
            rxs       <= sync1;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= perr_n;
`endif
        end
    end

    // Counter free-runs within a bit and is cleared at every sample and transition.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: if (cnt == MID) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n   = '0;
                shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                idx_n   = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (idx == TOP) state_n = PARITY;
`else
                if (idx == TOP) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == LAST) begin
                cnt_n     = '0;
                par_bad_n = rxs ^ (^shreg);
                state_n   = STOP;
            end
`endif
            STOP: if (cnt == LAST) begin
                cnt_n = '0;
                if (rxs) begin
                    data_n  = shreg;
                    valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    perr_n = par_bad;
`endif
                    state_n = IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = BREAK;
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames feed a scoreboard queue; a negedge monitor pops and checks every output pulse.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DB = 8;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = DB + 1 + int'(PAR);
    // raw start edge -> rxs low (2) -> t0 + HALF + NB*CPB + 1
    localparam int LAT = 2 + HALF + NB * CPB + 1;

    typedef struct {
        bit ferr;
        logic [7:0] data;
        int cyc;
        bit perr;
    } exp_t;

    logic clk, reset, rx;
    logic [DB-1:0] rx_data;
    logic rx_valid, frame_err, busy, perr;
    exp_t sbq[$];
    exp_t me;
    int cyc = 0;
    int passed = 0;
    int total = 0;
    bit busy_chk = 1'b0;
    int busy_n;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr),
`endif
        .busy(busy)
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Called at a negedge; returns at a negedge so frames can run back-to-back.
    task automatic send(input logic [7:0] d, input logic par, input logic stop,
                        input bit ferr, input logic [7:0] ed, input bit eperr);
        exp_t e;
        e.ferr = ferr;
        e.data = ed;
        e.perr = eperr;
        e.cyc = cyc + LAT;
        sbq.push_back(e);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (PAR) begin
            rx = par;
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (busy_chk) chk("busy_after_valid", int'(busy), 0);
            busy_chk = rx_valid;
            if (rx_valid || frame_err) begin
                chk("pulse_exclusive", int'(rx_valid && frame_err), 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", int'({rx_valid, frame_err}), 0);
                end else begin
                    me = sbq.pop_front();
                    chk("frame_err", int'(frame_err), int'(me.ferr));
                    chk("rx_valid", int'(rx_valid), int'(!me.ferr));
                    chk("rx_data", int'(rx_data), int'(me.data));
                    chk("pulse_cycle", cyc, me.cyc);
                    chk("parity_err", int'(perr), int'(me.perr));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send(8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
        repeat (20) @(negedge clk);

        send(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        send(8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
        repeat (20) @(negedge clk);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
        end
        chk("glitch_busy_1to9", int'(busy_n >= 1 && busy_n <= 9), 1);
        repeat (10) @(negedge clk);

        send(8'h3C, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        repeat (50) @(negedge clk);
        chk("break_busy", int'(busy), 1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_released", int'(busy), 0);
        chk("ferr_keeps_data", int'(rx_data), 8'h55);

        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h81 >> i);
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (HALF) @(negedge clk);
        #2 reset = 1'b1;
        rx = 1'b1;
        #1;
        chk("midreset_rx_data", int'(rx_data), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_pulses", int'({rx_valid, frame_err}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        send(8'h42, 1'b0, 1'b1, 1'b0, 8'h42, 1'b0);
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b0, 1'b1, 1'b0, 8'h07, 1'b1);
        repeat (20) @(negedge clk);
        send(8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0);
        repeat (20) @(negedge clk);
`endif

        repeat (50) @(negedge clk);
        chk("missing_pulses", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the receive end of the UART link whose transmit side is built from the team's parameterised bit/baud counters.
- Oversamples the asynchronous rx line with an internal cycle counter and samples at mid-bit.
- Shifts in LSB-first data and presents each byte as a single-cycle valid pulse.
- Sits between the pad/DUT serial line and the byte-level consumer (scoreboard, FIFO, or register interface).

Parameters:
- CLKS_PER_BIT, 16, clock cycles per bit period; must be >= 4 and even.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CNT_W, ceil(log2(CLKS_PER_BIT)), width of the internal cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset; asserting reset forces all state immediately, with no clock required.
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0.
  - state = IDLE, cycle counter = 0, bit index = 0, shift register = 0.
  - Both synchronizer flops = 1.
- Synchronizer: rx passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Cycle counter: counts 0..CLKS_PER_BIT-1. It is cleared on every state transition and on every bit sample.
- HALF is defined as CLKS_PER_BIT/2.
- IDLE: rxs == 0 goes to START with counter = 0. t0 denotes the IDLE cycle in which rxs is seen low.
- START: at count HALF-1, sample rxs.
  - 0: go to DATA with bit index = 0.
  - 1: false start; go to IDLE with no output pulses.
- DATA: at count CLKS_PER_BIT-1, shift rxs into bit [index], LSB first.
  - After bit DATA_BITS-1, go to STOP, or to PARITY when the optional feature is enabled.
- STOP: at count CLKS_PER_BIT-1, sample rxs.
  - 1: register rx_data <= shift register, pulse rx_valid for one cycle, go to IDLE.
  - 0: pulse frame_err for one cycle, leave rx_data unchanged, go to BREAK.
- BREAK: wait until rxs == 1, then go to IDLE. A held-low line produces exactly one frame_err.
- Latency: rx_valid is high in cycle t0 + HALF + (DATA_BITS+1)*CLKS_PER_BIT + 1.
  - Defaults give t0 + 153.
  - Add 2 cycles from a raw rx edge because of the synchronizer.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE is re-entered one cycle after the stop sample, which is well before the next falling edge.
- Pulse exclusivity: rx_valid and frame_err are never high in the same cycle.
- Mid-frame line activity: rx edges inside a frame are ignored except at the sample points. There is no resynchronisation on edges.
- Reset mid-frame: the partial frame is discarded, no pulses are generated, and outputs return to reset values.
- Width rules:
  - Bit index is wide enough to hold DATA_BITS.
  - Counter comparisons are at CNT_W.
  - The counter never wraps; it is cleared at each sample.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP, sampled at count CLKS_PER_BIT-1.
  - Parity is even over the data bits.
  - Output port parity_err (1 bit, reset 0) pulses one cycle with rx_valid when parity mismatches.
  - rx_data is still updated on a parity mismatch.
  - Latency grows by CLKS_PER_BIT, giving t0 + 169 at defaults.
- When not defined: there is no PARITY state and no parity_err port. The frame is 1 start bit, DATA_BITS data bits, and 1 stop bit.

Test Plan:
- Frame 0xA5, defaults, ideal 16-cycle bits: rx_data = 0xA5 and rx_valid high exactly one cycle at t0+153; busy low the following cycle.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap: three rx_valid pulses 160 cycles apart carrying 0x00, 0xFF, 0x55; frame_err never asserted.
- 3-cycle low glitch on an idle line: returns to IDLE after the START sample; no rx_valid or frame_err; busy high for at most 9 cycles.
- Frame 0x3C with stop bit driven 0, line then held low 50 cycles: one frame_err pulse; rx_data keeps its previous value; no activity until the line goes high.
- Reset asserted for 1 cycle during data bit 4 of 0x81, then a clean 0x42 frame: outputs zero immediately on reset with no pulse for 0x81; 0x42 received correctly.
- With UART_RX_PARITY_EN, frame 0x07 sent with parity bit 0 (wrong): rx_valid and parity_err pulse together at t0+169 with rx_data = 0x07. Repeating with parity bit 1 gives parity_err = 0.
